// File: rtl/timer_ctrl_pkg.sv
// Shared definitions for the interval timer controller and its counter datapath.
package timer_ctrl_pkg;

   localparam int unsigned WIDTH_DEF      = 8;
   localparam int unsigned PRESCALE_W_DEF = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      PAUSED = 2'd2
   } state_t;

endpackage : timer_ctrl_pkg

// File: rtl/tick_counter.sv
// Enable-gated up-counter that wraps to zero on the tick that meets its terminal value.
module tick_counter #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic [WIDTH-1:0] period,
   output logic [WIDTH-1:0] count,
   output logic             term_c
);

   assign term_c = (count == period);

   // clr outranks en so an abort never lets a terminal tick through.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         count <= term_c ? '0 : count + WIDTH'(1);
      end
   end

endmodule : tick_counter

// File: rtl/interval_timer_ctrl.sv
// Programmable interval timer: command FSM, prescaler, config latch and interrupt flags
// around a tick_counter datapath.
module interval_timer_ctrl
   import timer_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH      = WIDTH_DEF,
   parameter int unsigned PRESCALE_W = PRESCALE_W_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  pause,
   input  logic [WIDTH-1:0]      cfg_period,
   input  logic [PRESCALE_W-1:0] cfg_prescale,
   input  logic                  cfg_reload,
   input  logic                  irq_clr,
   output logic [WIDTH-1:0]      count,
   output logic                  busy,
   output logic                  paused,
   output logic                  done,
   output logic                  irq,
   output logic                  overrun,
   output logic                  start_err
);

   state_t                state;
   state_t                state_nxt;

   logic [WIDTH-1:0]      period_q;
   logic [PRESCALE_W-1:0] prescale_q;
   logic                  reload_q;
   logic [PRESCALE_W-1:0] psc;

   logic                  accept;
   logic                  advance;
   logic                  tick;
   logic                  terminal;
   logic                  cnt_clr;
   logic                  term_c;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; stop outranks pause and the terminal tick.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start && !stop) state_nxt = RUN;
         end
         RUN: begin
            if (stop)                       state_nxt = IDLE;
            else if (pause)                 state_nxt = PAUSED;
            else if (terminal && !reload_q) state_nxt = IDLE;
         end
         PAUSED: begin
            if (stop)        state_nxt = IDLE;
            else if (!pause) state_nxt = RUN;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath controls decoded from the current state and commands.
   always_comb begin
      accept   = 1'b0;
      advance  = 1'b0;
      tick     = 1'b0;
      cnt_clr  = 1'b0;
      terminal = 1'b0;
      case (state)
         IDLE: begin
            accept  = start && !stop;
            cnt_clr = accept;
         end
         RUN: begin
            cnt_clr = stop;
            advance = !stop && !pause;
            tick    = advance && (psc == prescale_q);
         end
         PAUSED: begin
            cnt_clr = stop;
         end
         default: ;
      endcase
      terminal = tick && term_c;
   end

   // Configuration is captured only when a start is accepted.
   always_ff @(posedge clk) begin
      if (rst) begin
         period_q   <= '0;
         prescale_q <= '0;
         reload_q   <= 1'b0;
      end else if (accept) begin
         period_q   <= cfg_period;
         prescale_q <= cfg_prescale;
         reload_q   <= cfg_reload;
      end
   end

   // Prescaler: one count tick every prescale_q+1 running cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         psc <= '0;
      end else if (cnt_clr) begin
         psc <= '0;
      end else if (advance) begin
         psc <= tick ? '0 : psc + PRESCALE_W'(1);
      end
   end

   tick_counter #(
      .WIDTH (WIDTH)
   ) u_tick_counter (
      .clk    (clk),
      .rst    (rst),
      .en     (tick),
      .clr    (cnt_clr),
      .period (period_q),
      .count  (count),
      .term_c (term_c)
   );

   // Status outputs registered from the next state so they align with count.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy      <= 1'b0;
         paused    <= 1'b0;
         done      <= 1'b0;
         start_err <= 1'b0;
      end else begin
         busy      <= (state_nxt != IDLE);
         paused    <= (state_nxt == PAUSED);
         done      <= terminal;
         start_err <= start && (state != IDLE);
      end
   end

   // Sticky flags; a clear coinciding with a new terminal event leaves irq set.
   always_ff @(posedge clk) begin
      if (rst) begin
         irq     <= 1'b0;
         overrun <= 1'b0;
      end else if (irq_clr) begin
         irq     <= terminal;
         overrun <= 1'b0;
      end else if (terminal) begin
         irq     <= 1'b1;
         overrun <= overrun | irq;
      end
   end

endmodule : interval_timer_ctrl

// File: tb/tb_interval_timer_ctrl.sv
// Directed self-checking bench for interval_timer_ctrl.
module tb_interval_timer_ctrl;
   import timer_ctrl_pkg::*;

   localparam int unsigned W  = 8;
   localparam int unsigned PW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          stop;
   logic          pause;
   logic [W-1:0]  cfg_period;
   logic [PW-1:0] cfg_prescale;
   logic          cfg_reload;
   logic          irq_clr;
   logic [W-1:0]  count;
   logic          busy;
   logic          paused;
   logic          done;
   logic          irq;
   logic          overrun;
   logic          start_err;

   int n_checks = 0;
   int n_fail   = 0;

   interval_timer_ctrl #(
      .WIDTH      (W),
      .PRESCALE_W (PW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .stop         (stop),
      .pause        (pause),
      .cfg_period   (cfg_period),
      .cfg_prescale (cfg_prescale),
      .cfg_reload   (cfg_reload),
      .irq_clr      (irq_clr),
      .count        (count),
      .busy         (busy),
      .paused       (paused),
      .done         (done),
      .irq          (irq),
      .overrun      (overrun),
      .start_err    (start_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Advance one rising edge and settle before sampling.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue a start at "edge 0" with the given configuration.
   task automatic begin_timer(input logic [W-1:0] p, input logic [PW-1:0] s, input logic r);
      cfg_period   = p;
      cfg_prescale = s;
      cfg_reload   = r;
      start        = 1'b1;
      step();
      start        = 1'b0;
   endtask

   task automatic clear_irq();
      irq_clr = 1'b1;
      step();
      irq_clr = 1'b0;
   endtask

   int seen;

   initial begin
      rst          = 1'b1;
      start        = 1'b0;
      stop         = 1'b0;
      pause        = 1'b0;
      cfg_period   = '0;
      cfg_prescale = '0;
      cfg_reload   = 1'b0;
      irq_clr      = 1'b0;
      step();
      step();
      rst = 1'b0;
      check("rst_count",   32'(count),   0);
      check("rst_busy",    32'(busy),    0);
      check("rst_paused",  32'(paused),  0);
      check("rst_done",    32'(done),    0);
      check("rst_irq",     32'(irq),     0);
      check("rst_overrun", 32'(overrun), 0);

      // Reset mid-RUN.
      begin_timer(8'd10, 4'd0, 1'b0);
      repeat (5) step();
      check("midrun_count", 32'(count), 5);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("midrst_count", 32'(count), 0);
      check("midrst_busy",  32'(busy),  0);
      check("midrst_done",  32'(done),  0);
      check("midrst_irq",   32'(irq),   0);
      seen = 0;
      repeat (15) begin
         step();
         if (done || busy) seen = 1;
      end
      check("midrst_quiet", 32'(seen), 0);

      // One-shot P=3, S=0.
      begin_timer(8'd3, 4'd0, 1'b0);
      check("os_busy0",  32'(busy),      1);
      check("os_err0",   32'(start_err), 0);
      check("os_count0", 32'(count),     0);
      for (int e = 1; e <= 3; e++) begin
         step();
         check("os_count", 32'(count), 32'(e));
         check("os_nodone", 32'(done), 0);
      end
      step();
      check("os_term_count", 32'(count), 0);
      check("os_term_done",  32'(done),  1);
      check("os_term_busy",  32'(busy),  0);
      check("os_term_irq",   32'(irq),   1);
      step();
      check("os_done_pulse", 32'(done), 0);
      check("os_irq_sticky", 32'(irq),  1);
      clear_irq();
      check("os_irq_clr", 32'(irq), 0);

      // Auto-reload P=2, S=1: done every 6 cycles, overrun on the second.
      begin_timer(8'd2, 4'd1, 1'b1);
      for (int e = 1; e <= 13; e++) begin
         step();
         check("rl_done", 32'(done), 32'(e == 6 || e == 12));
         if (e == 6)  check("rl_ovr_first",  32'(overrun), 0);
         if (e == 12) check("rl_ovr_second", 32'(overrun), 1);
      end
      check("rl_busy", 32'(busy), 1);
      stop    = 1'b1;
      irq_clr = 1'b1;
      step();
      stop    = 1'b0;
      irq_clr = 1'b0;
      check("rl_clr_irq",   32'(irq),     0);
      check("rl_clr_ovr",   32'(overrun), 0);
      check("rl_stop_busy", 32'(busy),    0);
      check("rl_stop_cnt",  32'(count),   0);

      // Pause P=5, S=0: pause sampled high at edges 3..6, resume edge 7,
      // advancing again from edge 8, so done moves from edge 6 to edge 11.
      begin_timer(8'd5, 4'd0, 1'b0);
      step();
      step();
      check("pz_count2", 32'(count), 2);
      pause = 1'b1;
      for (int e = 3; e <= 6; e++) begin
         step();
         check("pz_paused", 32'(paused), 1);
         check("pz_busy",   32'(busy),   1);
         check("pz_frozen", 32'(count),  2);
      end
      pause = 1'b0;
      step();
      check("pz_resume_paused", 32'(paused), 0);
      check("pz_resume_count",  32'(count),  2);
      for (int e = 8; e <= 12; e++) begin
         step();
         check("pz_done", 32'(done), 32'(e == 11));
      end
      clear_irq();

      // stop coincident with terminal tick, P=1, S=0.
      begin_timer(8'd1, 4'd0, 1'b0);
      step();
      check("st_count1", 32'(count), 1);
      stop = 1'b1;
      step();
      stop = 1'b0;
      check("st_done",  32'(done),  0);
      check("st_irq",   32'(irq),   0);
      check("st_count", 32'(count), 0);
      check("st_busy",  32'(busy),  0);
      step();
      check("st_done_after", 32'(done), 0);

      // start and stop together in IDLE.
      cfg_period = 8'd7;
      start      = 1'b1;
      stop       = 1'b1;
      step();
      start      = 1'b0;
      stop       = 1'b0;
      check("ss_busy", 32'(busy), 0);
      step();
      check("ss_busy_after", 32'(busy),  0);
      check("ss_count",      32'(count), 0);

      // start while running with a new period is rejected.
      begin_timer(8'd4, 4'd0, 1'b0);
      step();
      cfg_period = 8'd1;
      start      = 1'b1;
      step();
      start      = 1'b0;
      check("se_err",    32'(start_err), 1);
      check("se_count2", 32'(count),     2);
      step();
      check("se_err_pulse", 32'(start_err), 0);
      check("se_count3",    32'(count),     3);
      for (int e = 4; e <= 6; e++) begin
         step();
         check("se_done", 32'(done), 32'(e == 5));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_interval_timer_ctrl
